// File: rtl/alert_driver_if.sv
// Handshake bundle between game logic and the alert driver: start request in,
// LED/buzzer drive and sequence status out.
interface alert_driver_if #(
    parameter int CNT_W = 4
);
    logic             trig;
    logic [CNT_W-1:0] count_in;
    logic             led;
    logic             beep;
    logic             busy;
    logic             done;

    modport master (
        output trig,
        output count_in,
        input  led,
        input  beep,
        input  busy,
        input  done
    );

    modport slave (
        input  trig,
        input  count_in,
        output led,
        output beep,
        output busy,
        output done
    );
endinterface

// File: rtl/alert_driver.sv
// Turns a one-clock event pulse into N timed LED flashes with a gated buzzer tone.
// Optional macro ALERT_RETRIGGER_EN: a trig while busy restarts the sequence.
module alert_driver #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int TONE_DIV   = 25000,
    parameter int CNT_W      = 4
) (
    input  logic          clk,
    input  logic          reset,
    alert_driver_if.slave bus
);

    localparam int ON_W   = (ON_CYCLES  > 1) ? $clog2(ON_CYCLES)  : 1;
    localparam int OFF_W  = (OFF_CYCLES > 1) ? $clog2(OFF_CYCLES) : 1;
    localparam int TONE_W = (TONE_DIV   > 1) ? $clog2(TONE_DIV)   : 1;
    localparam int PH_W   = (ON_W > OFF_W) ? ON_W : OFF_W;

    localparam logic [PH_W-1:0]   ON_LAST   = PH_W'(ON_CYCLES - 1);
    localparam logic [PH_W-1:0]   OFF_LAST  = PH_W'(OFF_CYCLES - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_DONE = 3'd3
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_phase;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_tone;
    logic [TONE_W-1:0] r_toneCnt;
    logic              r_led;
    logic              r_beep;
    logic              r_busy;
    logic              r_done;

    state_t            w_nextState;
    logic [PH_W-1:0]   w_nextPhase;
    logic [CNT_W-1:0]  w_nextRemaining;
    logic              w_nextTone;
    logic [TONE_W-1:0] w_nextToneCnt;
    logic              w_ledNext;
    logic              w_beepNext;
    logic              w_busyNext;
    logic              w_doneNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_phase     <= '0;
            r_remaining <= '0;
            r_tone      <= 1'b0;
            r_toneCnt   <= '0;
            r_led       <= 1'b0;
            r_beep      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_phase     <= w_nextPhase;
            r_remaining <= w_nextRemaining;
            r_tone      <= w_nextTone;
            r_toneCnt   <= w_nextToneCnt;
            r_led       <= w_ledNext;
            r_beep      <= w_beepNext;
            r_busy      <= w_busyNext;
            r_done      <= w_doneNext;
        end
    end

    always_comb begin
        w_nextState     = S_IDLE;
        w_nextPhase     = '0;
        w_nextRemaining = r_remaining;
        w_nextTone      = 1'b0;
        w_nextToneCnt   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.trig) begin
                    w_nextRemaining = bus.count_in;
                    if (bus.count_in != '0) begin
                        w_nextState = S_ON;
                        w_nextTone  = 1'b1;
                    end else begin
                        w_nextState = S_DONE;
                    end
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            S_ON: begin
                // Last ON cycle: the final flash skips the OFF gap and goes straight to DONE.
                if (r_phase == ON_LAST) begin
                    w_nextRemaining = r_remaining - 1'b1;
                    if (r_remaining == CNT_ONE) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextState = S_OFF;
                    end
                end else begin
                    w_nextState = S_ON;
                    w_nextPhase = r_phase + 1'b1;
                    if (r_toneCnt == TONE_LAST) begin
                        w_nextToneCnt = '0;
                        w_nextTone    = ~r_tone;
                    end else begin
                        w_nextToneCnt = r_toneCnt + 1'b1;
                        w_nextTone    = r_tone;
                    end
                end
            end
            S_OFF: begin
                if (r_phase == OFF_LAST) begin
                    w_nextState = S_ON;
                    w_nextTone  = 1'b1;
                end else begin
                    w_nextState = S_OFF;
                    w_nextPhase = r_phase + 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState     = S_IDLE;
                w_nextRemaining = '0;
            end
        endcase
`ifdef ALERT_RETRIGGER_EN
        if (bus.trig && (r_state == S_ON || r_state == S_OFF || r_state == S_DONE)) begin
            w_nextRemaining = bus.count_in;
            w_nextPhase     = '0;
            w_nextToneCnt   = '0;
            if (bus.count_in != '0) begin
                w_nextState = S_ON;
                w_nextTone  = 1'b1;
            end else begin
                w_nextState = S_DONE;
                w_nextTone  = 1'b0;
            end
        end
`endif
    end

    // Outputs are decoded from the upcoming state so they register on the same edge.
    always_comb begin
        w_ledNext  = (w_nextState == S_ON);
        w_beepNext = (w_nextState == S_ON) && w_nextTone;
        w_busyNext = (w_nextState != S_IDLE);
        w_doneNext = (w_nextState == S_DONE);
    end

    assign bus.led  = r_led;
    assign bus.beep = r_beep;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_alert_driver.sv
// Directed bench for alert_driver with short timing (ON=4, OFF=3, TONE_DIV=2).
// Per-cycle outputs are packed into vectors, cycle 1 after the trig edge in the most significant used bit.
module tb_alert_driver;

    localparam int ON_CYCLES  = 4;
    localparam int OFF_CYCLES = 3;
    localparam int TONE_DIV   = 2;
    localparam int CNT_W      = 4;

    logic clk = 1'b0;
    logic reset;

    alert_driver_if #(.CNT_W(CNT_W)) bus ();

    alert_driver #(
        .ON_CYCLES (ON_CYCLES),
        .OFF_CYCLES(OFF_CYCLES),
        .TONE_DIV  (TONE_DIV),
        .CNT_W     (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [63:0] ledVec;
    logic [63:0] beepVec;
    logic [63:0] busyVec;
    logic [63:0] doneVec;
    int ledRises;
    int ledCycles;
    int busyCycles;
    int doneCount;
    int doneCycle;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Pulse trig for one edge; count_in is scrambled afterwards so resampling would show.
    task automatic applyStimulus(input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        bus.trig     = 1'b1;
        bus.count_in = cnt;
        @(posedge clk);
        #1;
        bus.trig     = 1'b0;
        bus.count_in = ~cnt;
    endtask

    task automatic captureCycles(input int n, input int trigAt, input logic [CNT_W-1:0] trigCount,
                                 input int resetAt);
        logic prevLed;
        prevLed    = 1'b0;
        ledVec     = '0;
        beepVec    = '0;
        busyVec    = '0;
        doneVec    = '0;
        ledRises   = 0;
        ledCycles  = 0;
        busyCycles = 0;
        doneCount  = 0;
        doneCycle  = 0;
        for (int i = 1; i <= n; i++) begin
            ledVec  = {ledVec[62:0], bus.led};
            beepVec = {beepVec[62:0], bus.beep};
            busyVec = {busyVec[62:0], bus.busy};
            doneVec = {doneVec[62:0], bus.done};
            if (bus.led && !prevLed) ledRises++;
            prevLed = bus.led;
            if (bus.led) ledCycles++;
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                doneCount++;
                doneCycle = i;
            end
            if (i == trigAt) begin
                bus.trig     = 1'b1;
                bus.count_in = trigCount;
            end
            if (i == resetAt) reset = 1'b1;
            @(posedge clk);
            #1;
            bus.trig = 1'b0;
            reset    = 1'b0;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.trig     = 1'b0;
        bus.count_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset led",  64'(bus.led),  64'd0);
        checkOutput("reset beep", 64'(bus.beep), 64'd0);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] single flash");
        applyStimulus(4'd1);
        captureCycles(6, 0, 4'd0, 0);
        checkOutput("t1 led",  ledVec,  64'h3C);
        checkOutput("t1 beep", beepVec, 64'h30);
        checkOutput("t1 busy", busyVec, 64'h3E);
        checkOutput("t1 done", doneVec, 64'h02);

        $display("[TB] three flashes");
        applyStimulus(4'd3);
        captureCycles(20, 0, 4'd0, 0);
        checkOutput("t2 led",  ledVec,  64'hF1E3C);
        checkOutput("t2 beep", beepVec, 64'hC1830);
        checkOutput("t2 busy", busyVec, 64'hFFFFE);
        checkOutput("t2 done", doneVec, 64'h2);
        checkOutput("t2 rises", 64'(ledRises), 64'd3);

        $display("[TB] zero count");
        applyStimulus(4'd0);
        captureCycles(3, 0, 4'd0, 0);
        checkOutput("t3 led",  ledVec,  64'h0);
        checkOutput("t3 beep", beepVec, 64'h0);
        checkOutput("t3 busy", busyVec, 64'h4);
        checkOutput("t3 done", doneVec, 64'h4);

        $display("[TB] trig during second flash");
        applyStimulus(4'd2);
        captureCycles(45, 9, 4'd5, 0);
`ifdef ALERT_RETRIGGER_EN
        checkOutput("t4 rises", 64'(ledRises),   64'd6);
        checkOutput("t4 ledcy", 64'(ledCycles),  64'd26);
        checkOutput("t4 busy",  64'(busyCycles), 64'd42);
        checkOutput("t4 dones", 64'(doneCount),  64'd1);
        checkOutput("t4 donat", 64'(doneCycle),  64'd42);
`else
        checkOutput("t4 rises", 64'(ledRises),   64'd2);
        checkOutput("t4 ledcy", 64'(ledCycles),  64'd8);
        checkOutput("t4 busy",  64'(busyCycles), 64'd12);
        checkOutput("t4 dones", 64'(doneCount),  64'd1);
        checkOutput("t4 donat", 64'(doneCycle),  64'd12);
`endif

        $display("[TB] reset during OFF");
        applyStimulus(4'd3);
        captureCycles(10, 0, 4'd0, 6);
        checkOutput("t5 led",   ledVec,  64'h3C0);
        checkOutput("t5 beep",  beepVec, 64'h300);
        checkOutput("t5 busy",  busyVec, 64'h3F0);
        checkOutput("t5 dones", 64'(doneCount), 64'd0);
        applyStimulus(4'd1);
        captureCycles(6, 0, 4'd0, 0);
        checkOutput("t5 post led",  ledVec,  64'h3C);
        checkOutput("t5 post busy", busyVec, 64'h3E);
        checkOutput("t5 post done", doneVec, 64'h02);

        $display("[TB] maximum count");
        applyStimulus(4'd15);
`ifdef ALERT_RETRIGGER_EN
        captureCycles(110, 0, 4'd2, 0);
`else
        captureCycles(110, 103, 4'd2, 0);
`endif
        checkOutput("t6 rises", 64'(ledRises),   64'd15);
        checkOutput("t6 ledcy", 64'(ledCycles),  64'd60);
        checkOutput("t6 busy",  64'(busyCycles), 64'd103);
        checkOutput("t6 dones", 64'(doneCount),  64'd1);
        checkOutput("t6 donat", 64'(doneCycle),  64'd103);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/alert_driver.md
Name: alert_driver

Overview:
- Output-side counterpart to button conditioning. Converts a single-cycle event pulse from game logic into a human-perceptible alert: N timed LED flashes with a gated buzzer tone.
- Sits between the game FSM (wrong cut, tick, defuse) and the board LED/buzzer pins.
- Requests arrive as one-clock pulses, the same form the button conditioner produces.

Parameters:
- ON_CYCLES, 25000000, length of each flash/beep in clk cycles (>=1)
- OFF_CYCLES, 12500000, gap between flashes in clk cycles (>=1)
- TONE_DIV, 25000, half-period of buzzer square wave in clk cycles (>=1)
- CNT_W, 4, width of flash-count input

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high; clears all state and outputs on the next posedge
- trig  input  1  one-cycle start request
- count_in  input  CNT_W  number of flashes; sampled only on an accepted trig
- led  output  1  high during each ON phase
- beep  output  1  buzzer drive = led AND tone square wave
- busy  output  1  high from accepted trig until the sequence ends
- done  output  1  one-cycle pulse at sequence end

Behaviour:
- All outputs are registered. Reset values: led=0, beep=0, busy=0, done=0, state=IDLE, all counters=0. Reset has priority over trig.
- States:
  - IDLE: busy=0. If trig=1 on an edge: latch remaining=count_in.
    - count_in!=0: enter ON, phase counter=0, tone=1. So led=1, beep=1, busy=1 are visible right after the sampling edge.
    - count_in==0: enter DONE directly. led stays 0.
  - ON: led=1, beep=tone.
    - Phase counter counts 0..ON_CYCLES-1, so led is high exactly ON_CYCLES cycles.
    - Tone toggles every TONE_DIV cycles, counted from ON entry.
    - At the terminal count, decrement remaining:
      - remaining was 1: go to DONE. No trailing OFF phase.
      - otherwise: go to OFF, phase counter=0.
  - OFF: led=0, beep=0. Lasts exactly OFF_CYCLES cycles, then returns to ON with phase counter=0 and tone=1. Every flash therefore starts with beep high.
  - DONE: done=1, busy=1, led=0, beep=0 for exactly one cycle, then IDLE.
- Invalid or unused state encodings: go to IDLE with all outputs cleared.
- Total busy length for N>=1 flashes: N*ON_CYCLES + (N-1)*OFF_CYCLES + 1 cycles.
- trig while busy (ON/OFF/DONE): ignored, and count_in is not resampled. This is the default; see Optional Feature.
- trig on the same edge the block returns DONE→IDLE: ignored. Only trig sampled while in IDLE is accepted.
- count_in at its maximum (2^CNT_W-1): full count honoured, no wrap.
- Counter widths: $clog2 of each parameter, minimum 1 bit. The compare is exact, so ON_CYCLES=1 and OFF_CYCLES=1 are legal.
- reset mid-sequence: next edge returns to IDLE. led, beep, busy fall, and no done pulse is produced.

Optional Feature:
- Macro: ALERT_RETRIGGER_EN.
- Defined: trig=1 in ON, OFF or DONE restarts the sequence. remaining reloads from count_in and the block enters ON with phase counter=0 and tone=1. No done pulse is emitted for the abandoned sequence. A retrigger with count_in==0 goes to DONE.
- Undefined: trig while busy is ignored, as in Behaviour.

Test Plan:
Use ON_CYCLES=4, OFF_CYCLES=3, TONE_DIV=2, CNT_W=4.
1. Single flash: trig=1 for one cycle with count_in=1 → led high 4 cycles, beep pattern 1,1,0,0, then done high for one cycle; busy high 5 cycles total.
2. Three flashes: count_in=3 → led pattern 4 on / 3 off / 4 on / 3 off / 4 on, then done; busy high 19 cycles; each ON phase starts with beep=1.
3. Zero count: count_in=0 → led and beep never rise; done pulses on the cycle after trig; busy high 1 cycle.
4. Busy retrigger, macro undefined: trig with count_in=5 during the 2nd flash of a count_in=2 sequence → only 2 flashes; done fires once at the cycle-12 end. With ALERT_RETRIGGER_EN defined → sequence restarts at the trig edge, 5 flashes follow, and exactly one done pulse occurs at the end.
5. Reset mid-operation: reset=1 during the OFF phase of a count_in=3 sequence → all outputs 0 on the next edge; no done pulse; a subsequent trig with count_in=1 gives a normal single flash.
6. Boundary: count_in=15 → exactly 15 led rising edges and one done pulse; trig asserted the same cycle as done is ignored.
